// File: rtl/canvas_feature_extractor_pkg.sv
// Shared definitions for the canvas feature extractor.
// Holds the scan FSM state encoding, the default result character codes
// and sizing constants used by the top level.
package canvas_feature_extractor_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default result codes: blank canvas / canvas with ink
    localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;
    localparam logic [7:0] INK_CHAR_DEFAULT   = 8'h41;

    // Read latency is bounded to 1..4, so a 3-bit drain counter is enough
    localparam int unsigned MAX_READ_LATENCY = 4;
    localparam int unsigned DRAIN_CNT_W      = 3;

endpackage

// File: rtl/canvas_feature_extractor_if.sv
// Bus bundle between the canvas feature extractor and its environment.
// master : the extractor (issues pixel reads, presents the result)
// slave  : the environment (starts scans, returns pixel data)
// Signals: in_start, read_data (to extractor); read_addr, read_enable,
// pending, result_valid, result, ink_count, x_min/x_max, y_min/y_max
// (from extractor).
interface canvas_feature_extractor_if #(
    parameter int unsigned XW = 5,
    parameter int unsigned YW = 5
);
    logic                 in_start;
    logic                 read_data;
    logic [XW+YW-1:0]     read_addr;
    logic                 read_enable;
    logic                 pending;
    logic                 result_valid;
    logic [7:0]           result;
    logic [XW+YW:0]       ink_count;
    logic [XW-1:0]        x_min;
    logic [XW-1:0]        x_max;
    logic [YW-1:0]        y_min;
    logic [YW-1:0]        y_max;

    modport master (
        input  in_start, read_data,
        output read_addr, read_enable, pending, result_valid,
               result, ink_count, x_min, x_max, y_min, y_max
    );

    modport slave (
        output in_start, read_data,
        input  read_addr, read_enable, pending, result_valid,
               result, ink_count, x_min, x_max, y_min, y_max
    );
endinterface

// File: rtl/canvas_feature_extractor_feature_delay_line.sv
// feature_delay_line: delays a {tag, coordinate} pair by DEPTH cycles so
// that each returning pixel can be matched with the address that fetched it.
// Ports: clk, rst (sync, active-high), in_tag/in_coord (issue side),
// out_tag/out_coord (aligned with read data). Tags clear on reset.
module feature_delay_line #(
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_tag,
    input  logic [COORD_W-1:0] in_coord,
    output logic               out_tag,
    output logic [COORD_W-1:0] out_coord
);

    logic [DEPTH-1:0]   tag_q;
    logic [COORD_W-1:0] coord_q [DEPTH];

    // Shift register, stage 0 nearest the issue side
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                coord_q[i] <= '0;
            end
        end else begin
            tag_q[0]   <= in_tag;
            coord_q[0] <= in_coord;
            for (int i = 1; i < int'(DEPTH); i++) begin
                tag_q[i]   <= tag_q[i-1];
                coord_q[i] <= coord_q[i-1];
            end
        end
    end

    assign out_tag   = tag_q[DEPTH-1];
    assign out_coord = coord_q[DEPTH-1];

endmodule

// File: rtl/canvas_feature_extractor.sv
// canvas_feature_extractor: scans a 2^XW x 2^YW one-bit canvas through a
// fixed-latency read port and reports ink count, bounding box and a
// blank/ink character code.
// Ports: clk, rst (sync, active-high), bus (master modport):
//   in_start      - request a scan (honoured only when idle)
//   read_addr/read_enable/read_data - pixel read port, {y,x} row-major
//   pending       - scan in progress or result being presented
//   result_valid  - one-cycle pulse when the result outputs update
//   result, ink_count, x_min, x_max, y_min, y_max - held scan results
module canvas_feature_extractor
    import canvas_feature_extractor_pkg::*;
#(
    parameter int unsigned XW           = 5,
    parameter int unsigned YW           = 5,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [7:0]  BLANK_CHAR   = BLANK_CHAR_DEFAULT,
    parameter logic [7:0]  INK_CHAR     = INK_CHAR_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    canvas_feature_extractor_if.master bus
);

    localparam int unsigned AW  = XW + YW;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DCW = DRAIN_CNT_W;
    localparam logic [AW-1:0]  LAST_ADDR  = '1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(READ_LATENCY - 1);

    state_t state;
    state_t state_next;

    logic [AW-1:0]  addr_q;
    logic           read_en_q;
    logic           pending_q;
    logic           valid_q;
    logic [DCW-1:0] drain_cnt;

    logic           d_tag;
    logic [AW-1:0]  d_coord;
    logic [XW-1:0]  d_x;
    logic [YW-1:0]  d_y;

    logic [CW-1:0]  ink_cnt;
    logic [XW-1:0]  xmin_q;
    logic [XW-1:0]  xmax_q;
    logic [YW-1:0]  ymin_q;
    logic [YW-1:0]  ymax_q;
    logic [CW-1:0]  cnt_next;
    logic [XW-1:0]  xmin_next;
    logic [XW-1:0]  xmax_next;
    logic [YW-1:0]  ymin_next;
    logic [YW-1:0]  ymax_next;

    logic [7:0]     result_q;
    logic [CW-1:0]  ink_count_q;
    logic [XW-1:0]  x_min_q;
    logic [XW-1:0]  x_max_q;
    logic [YW-1:0]  y_min_q;
    logic [YW-1:0]  y_max_q;

    logic           scan_start;
    logic           done_load;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.in_start) state_next = ST_SCAN;
            ST_SCAN:  if (addr_q == LAST_ADDR) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign scan_start = (state == ST_IDLE) && bus.in_start;
    assign done_load  = (state == ST_DRAIN) && (state_next == ST_DONE);

    // Control outputs registered from the next state so they line up with it;
    // the address counter sits at zero whenever no read is being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            read_en_q <= 1'b0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            read_en_q <= (state_next == ST_SCAN);
            pending_q <= (state_next != ST_IDLE);
            valid_q   <= (state_next == ST_DONE);
            if ((state == ST_SCAN) && (state_next == ST_SCAN)) begin
                addr_q <= addr_q + AW'(1);
            end else begin
                addr_q <= '0;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DCW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Carries the issue tag and {y,x} alongside the memory latency
    feature_delay_line #(
        .DEPTH   (READ_LATENCY),
        .COORD_W (AW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_tag    (read_en_q),
        .in_coord  (addr_q),
        .out_tag   (d_tag),
        .out_coord (d_coord)
    );

    assign d_x = d_coord[XW-1:0];
    assign d_y = d_coord[AW-1:XW];

    // Accumulator update for the pixel returning this cycle
    always_comb begin
        cnt_next  = ink_cnt;
        xmin_next = xmin_q;
        xmax_next = xmax_q;
        ymin_next = ymin_q;
        ymax_next = ymax_q;
        if (d_tag && bus.read_data) begin
            cnt_next = ink_cnt + CW'(1);
            if (d_x < xmin_q) xmin_next = d_x;
            if (d_x > xmax_q) xmax_next = d_x;
            if (d_y < ymin_q) ymin_next = d_y;
            if (d_y > ymax_q) ymax_next = d_y;
        end
    end

    // Running accumulators, re-armed at the start of every scan
    always_ff @(posedge clk) begin
        if (rst || scan_start) begin
            ink_cnt <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
        end else begin
            ink_cnt <= cnt_next;
            xmin_q  <= xmin_next;
            xmax_q  <= xmax_next;
            ymin_q  <= ymin_next;
            ymax_q  <= ymax_next;
        end
    end

    // Result capture: the last pixel arrives on the same edge that enters
    // DONE, so the results load from the accumulator next-values.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            ink_count_q <= '0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
        end else if (done_load) begin
            ink_count_q <= cnt_next;
            if (cnt_next == '0) begin
                result_q <= BLANK_CHAR;
                x_min_q  <= '0;
                x_max_q  <= '0;
                y_min_q  <= '0;
                y_max_q  <= '0;
            end else begin
                result_q <= INK_CHAR;
                x_min_q  <= xmin_next;
                x_max_q  <= xmax_next;
                y_min_q  <= ymin_next;
                y_max_q  <= ymax_next;
            end
        end
    end

    assign bus.read_addr    = addr_q;
    assign bus.read_enable  = read_en_q;
    assign bus.pending      = pending_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.ink_count    = ink_count_q;
    assign bus.x_min        = x_min_q;
    assign bus.x_max        = x_max_q;
    assign bus.y_min        = y_min_q;
    assign bus.y_max        = y_max_q;

endmodule

// File: tb/tb_canvas_feature_extractor.sv
// Testbench for canvas_feature_extractor: two instances (read latency 1
// and 3) scan the same canvas held in the bench; results are compared with
// a reference computed directly from the canvas contents.
module tb_canvas_feature_extractor;

    localparam int NPIX = 1024;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    canvas_feature_extractor_if #(.XW(5), .YW(5)) bus1 ();
    canvas_feature_extractor_if #(.XW(5), .YW(5)) bus3 ();

    canvas_feature_extractor #(.XW(5), .YW(5), .READ_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    canvas_feature_extractor #(.XW(5), .YW(5), .READ_LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Canvas memory; unaddressed cycles return random junk
    logic pix [NPIX];
    logic [2:0] pipe3;

    always @(posedge clk) begin
        bus1.read_data <= bus1.read_enable ? pix[bus1.read_addr] : 1'($urandom);
        pipe3 <= {pipe3[1:0], bus3.read_enable ? pix[bus3.read_addr] : 1'($urandom)};
    end
    assign bus3.read_data = pipe3[2];

    int n_cmp  = 0;
    int n_fail = 0;

    int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;
    logic [7:0] e_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count and bounding box straight from the canvas
    task automatic model();
        e_cnt = 0; e_xmin = W; e_xmax = -1; e_ymin = W; e_ymax = -1;
        for (int y = 0; y < W; y++) begin
            for (int x = 0; x < W; x++) begin
                if (pix[y*W + x]) begin
                    e_cnt++;
                    if (x < e_xmin) e_xmin = x;
                    if (x > e_xmax) e_xmax = x;
                    if (y < e_ymin) e_ymin = y;
                    if (y > e_ymax) e_ymax = y;
                end
            end
        end
        if (e_cnt == 0) begin
            e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
            e_res = 8'h20;
        end else begin
            e_res = 8'h41;
        end
    endtask

    task automatic fill(input int pct);
        for (int i = 0; i < NPIX; i++) pix[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic fill_box();
        int x0, x1, y0, y1;
        x0 = $urandom_range(0, 31); x1 = $urandom_range(x0, 31);
        y0 = $urandom_range(0, 31); y1 = $urandom_range(y0, 31);
        fill(0);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix[y*W + x] = ($urandom_range(0, 3) == 0);
        pix[y0*W + x0] = 1'b1;
        pix[y1*W + x1] = 1'b1;
    endtask

    task automatic chk_reset(input string who, input logic pend, input logic re,
                             input logic rv, input logic [9:0] ra, input logic [7:0] res,
                             input logic [10:0] cnt, input logic [4:0] xmn, input logic [4:0] xmx,
                             input logic [4:0] ymn, input logic [4:0] ymx);
        chk({who, " rst pending"}, pend, 0);
        chk({who, " rst read_enable"}, re, 0);
        chk({who, " rst result_valid"}, rv, 0);
        chk({who, " rst read_addr"}, ra, 0);
        chk({who, " rst result"}, res, 0);
        chk({who, " rst ink_count"}, cnt, 0);
        chk({who, " rst x_min"}, xmn, 0);
        chk({who, " rst x_max"}, xmx, 0);
        chk({who, " rst y_min"}, ymn, 0);
        chk({who, " rst y_max"}, ymx, 0);
    endtask

    task automatic chk_reset_both();
        chk_reset("dut1", bus1.pending, bus1.read_enable, bus1.result_valid, bus1.read_addr,
                  bus1.result, bus1.ink_count, bus1.x_min, bus1.x_max, bus1.y_min, bus1.y_max);
        chk_reset("dut3", bus3.pending, bus3.read_enable, bus3.result_valid, bus3.read_addr,
                  bus3.result, bus3.ink_count, bus3.x_min, bus3.x_max, bus3.y_min, bus3.y_max);
    endtask

    // Expected read-port / pending behaviour c cycles after the start cycle
    task automatic chk_cycle(input string who, input int c, input int lat,
                             input logic re, input logic [9:0] ra, input logic pend);
        logic exp_re;
        exp_re = (c >= 1) && (c <= NPIX);
        chk($sformatf("%s read_enable c%0d", who, c), re, exp_re);
        chk($sformatf("%s read_addr c%0d", who, c), ra, exp_re ? 32'(c - 1) : 32'd0);
        chk($sformatf("%s pending c%0d", who, c), pend, (c >= 1) && (c <= NPIX + lat + 1));
    endtask

    task automatic chk_result(input string who, input logic [7:0] res, input logic [10:0] cnt,
                              input logic [4:0] xmn, input logic [4:0] xmx,
                              input logic [4:0] ymn, input logic [4:0] ymx);
        chk({who, " result"}, res, e_res);
        chk({who, " ink_count"}, cnt, e_cnt);
        chk({who, " x_min"}, xmn, e_xmin);
        chk({who, " x_max"}, xmx, e_xmax);
        chk({who, " y_min"}, ymn, e_ymin);
        chk({who, " y_max"}, ymx, e_ymax);
    endtask

    // One full scan on both instances; optional stray in_start pulses
    task automatic run_scan(input string name, input bit pulse);
        int vc1, vc3, nv1, nv3;
        vc1 = -1; vc3 = -1; nv1 = 0; nv3 = 0;
        model();
        @(posedge clk); #1;
        bus1.in_start = 1'b1;
        bus3.in_start = 1'b1;
        chk({name, " dut1 pending c0"}, bus1.pending, 0);
        chk({name, " dut3 pending c0"}, bus3.pending, 0);
        for (int c = 1; c <= NPIX + 16; c++) begin
            @(posedge clk); #1;
            bus1.in_start = pulse && (c == 5 || c == NPIX + 2);
            bus3.in_start = pulse && (c == 5 || c == NPIX + 2);
            chk_cycle({name, " dut1"}, c, 1, bus1.read_enable, bus1.read_addr, bus1.pending);
            chk_cycle({name, " dut3"}, c, 3, bus3.read_enable, bus3.read_addr, bus3.pending);
            if (bus1.result_valid === 1'b1) begin nv1++; vc1 = c; end
            if (bus3.result_valid === 1'b1) begin nv3++; vc3 = c; end
        end
        bus1.in_start = 1'b0;
        bus3.in_start = 1'b0;
        chk({name, " dut1 valid cycle"}, vc1, NPIX + 2);
        chk({name, " dut1 valid pulses"}, nv1, 1);
        chk({name, " dut3 valid cycle"}, vc3, NPIX + 4);
        chk({name, " dut3 valid pulses"}, nv3, 1);
        chk_result({name, " dut1"}, bus1.result, bus1.ink_count,
                   bus1.x_min, bus1.x_max, bus1.y_min, bus1.y_max);
        chk_result({name, " dut3"}, bus3.result, bus3.ink_count,
                   bus3.x_min, bus3.x_max, bus3.y_min, bus3.y_max);
    endtask

    // Scan aborted by reset in cycle 500; no result may follow
    task automatic abort_scan();
        int nv;
        nv = 0;
        @(posedge clk); #1;
        bus1.in_start = 1'b1;
        bus3.in_start = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            @(posedge clk); #1;
            bus1.in_start = 1'b0;
            bus3.in_start = 1'b0;
            chk_cycle("abort dut1", c, 1, bus1.read_enable, bus1.read_addr, bus1.pending);
            chk_cycle("abort dut3", c, 3, bus3.read_enable, bus3.read_addr, bus3.pending);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_both();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (bus1.result_valid !== 1'b0) nv++;
            if (bus3.result_valid !== 1'b0) nv++;
            if (bus1.pending !== 1'b0) nv++;
            if (bus3.pending !== 1'b0) nv++;
        end
        chk("abort no activity after reset", nv, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus1.in_start = 1'b0;
        bus3.in_start = 1'b0;
        pipe3 = '0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_both();
        rst = 1'b0;

        fill(0);
        run_scan("empty", 1'b0);

        fill(0);
        pix[7*W + 3] = 1'b1;
        run_scan("single", 1'b0);

        fill(100);
        run_scan("full", 1'b0);

        fill(0);
        pix[0] = 1'b1;
        pix[NPIX-1] = 1'b1;
        run_scan("corners", 1'b0);

        fill(5);
        run_scan("stray_start", 1'b1);

        for (int k = 0; k < 2; k++) begin
            fill(int'($urandom_range(1, 60)));
            run_scan($sformatf("rand%0d", k), 1'b0);
        end

        fill_box();
        run_scan("box", 1'b0);

        fill(30);
        abort_scan();
        fill_box();
        run_scan("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/canvas_feature_extractor.md
CANVAS_FEATURE_EXTRACTOR -- requirements
Module: canvas_feature_extractor

Interface
REQ-001 Parameter XW, default 5, canvas column-index width; canvas width W = 2^XW.
REQ-002 Parameter YW, default 5, canvas row-index width; canvas height H = 2^YW.
REQ-003 Parameter READ_LATENCY, default 1, cycles from read_addr to read_data; legal range 1..4.
REQ-004 Parameter BLANK_CHAR, default 8'h20, result code for an empty canvas.
REQ-005 Parameter INK_CHAR, default 8'h41, result code for a non-empty canvas.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 in_start  in  1  request a scan; sampled only in IDLE.
REQ-009 read_data  in  1  pixel value (1 = ink) for the address issued READ_LATENCY cycles earlier.
REQ-010 read_addr  out  XW+YW  pixel address, {y,x}, row-major.
REQ-011 read_enable  out  1  high while read_addr is valid.
REQ-012 pending  out  1  high while a scan is in progress or its result is being presented.
REQ-013 result_valid  out  1  one-cycle pulse when the outputs below are updated.
REQ-014 result  out  8  character code.
REQ-015 ink_count  out  XW+YW+1  number of ink pixels.
REQ-016 x_min, x_max  out  XW each  bounding-box columns.
REQ-017 y_min, y_max  out  YW each  bounding-box rows.

Function
REQ-018 FSM states: IDLE, SCAN, DRAIN, DONE; all outputs registered or decoded from state only.
REQ-019 IDLE->SCAN when in_start=1; otherwise stay in IDLE.
REQ-020 SCAN: read_enable=1; read_addr counts 0..W*H-1, one per cycle; after W*H-1, go to DRAIN.
REQ-021 DRAIN: read_enable=0; lasts exactly READ_LATENCY cycles; then go to DONE.
REQ-022 DONE: lasts one cycle with result_valid=1; then go to IDLE.
REQ-023 pending=1 in SCAN, DRAIN, DONE; pending=0 in IDLE.
REQ-024 A valid tag and the {y,x} coordinate shall be delayed READ_LATENCY cycles alongside each issued address; read_data is accumulated only when the delayed tag=1.
REQ-025 Per accumulated ink pixel:
- ink counter +1 (never saturates; max W*H fits its width)
- running min/max of x and y updated
REQ-026 Running min/max registers at scan start: min = all-ones, max = 0; ink counter = 0.
REQ-027 Timing: in_start accepted in cycle 0 -> first address issued in cycle 1 -> result_valid in cycle W*H+READ_LATENCY+1.
REQ-028 On entry to DONE, result outputs are loaded:
- ink_count from the ink counter
- result = BLANK_CHAR if the count is 0, else INK_CHAR
- bbox from running min/max
- empty canvas: x_min, x_max, y_min, y_max all 0
REQ-029 Result outputs hold their values until the next DONE or reset.
REQ-030 in_start is ignored in SCAN, DRAIN and DONE, with no queuing.
REQ-031 read_addr = 0 whenever read_enable = 0.

Reset
REQ-032 rst=1 forces IDLE from any state, including mid-SCAN or mid-DRAIN; the partial scan is discarded.
REQ-033 Reset values: pending, read_enable, result_valid = 0; read_addr, result, ink_count, bbox outputs = 0; delay-line tags = 0.
REQ-034 rst has priority over in_start in the same cycle.

Structure
REQ-035 Shared package holds the FSM state encoding and the default BLANK_CHAR/INK_CHAR constants.
REQ-036 One sub-module, feature_delay_line, carries the {tag, y, x} pipeline of depth READ_LATENCY.

Verification (XW=YW=5, 1024 pixels, unless stated)
REQ-037 Empty canvas, L=1, start at cycle 0 -> result_valid only in cycle 1026; result=8'h20; ink_count=0; bbox all 0.
REQ-038 Single ink pixel at x=3, y=7 (addr 227) -> ink_count=1; x_min=x_max=3; y_min=y_max=7; result=8'h41.
REQ-039 Full-ink canvas -> ink_count=1024; x 0..31; y 0..31.
REQ-040 L=3, ink at addresses 0 and 1023 -> result_valid in cycle 1028; bbox 0..31 x 0..31; ink_count=2.
REQ-041 in_start pulsed in cycles 5 and 1026 of a scan -> no second scan; pending falls after cycle 1026.
REQ-042 rst in cycle 500, then a new start -> fresh result with no carry-over; no result_valid from the aborted scan.
